// File: rtl/configure.sv
// Default build-time configuration for memory_responder: base address, depth in words, wait cycles.
package configure;

  localparam logic [31:0] mem_base  = 32'h0000_0000;
  localparam int          mem_depth = 1024;
  localparam int          mem_wait  = 1;

endpackage

// File: rtl/wires.sv
// Shared types for memory_responder: FSM state encoding and the latched request.
package wires;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

endpackage

// File: rtl/memory_array.sv
// DEPTH x 32 word storage with per-byte write enables and an asynchronous read port.
module memory_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_lane
      logic [7:0] lane [DEPTH];

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          lane[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane[addr];
    end
  endgenerate

endmodule

// File: rtl/memory_responder.sv
// Single-port memory responder with a fixed-latency valid/ready handshake.
// Optional macro MEMORY_RESPONDER_BOUNDS_EN enables out-of-range detection and a sticky error flag.
module memory_responder
  import wires::*;
#(
  parameter logic [31:0] BASE  = configure::mem_base,
  parameter int          DEPTH = configure::mem_depth,
  parameter int          WAIT  = configure::mem_wait
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        memory_error
);

  localparam int AW = $clog2(DEPTH);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  req_t        req_reg;
  logic        ready_reg;
  logic [31:0] rdata_reg;

  logic [31:0]   cur_addr;
  logic [3:0]    cur_wstrb;
  logic          cur_instr;
  logic          cur_write;
  logic [31:0]   cur_off;
  logic [AW-1:0] cur_idx;
  logic          cur_in_range;
  logic          enter_resp;
  logic          arr_we;
  logic [31:0]   arr_rdata;
  logic [31:0]   resp_data;

  // The request being serviced: live inputs on the accept edge, the latched copy afterwards.
  always_comb begin
    cur_addr  = req_reg.addr;
    cur_wstrb = req_reg.wstrb;
    cur_instr = req_reg.instr;
    if (state_reg == ST_IDLE) begin
      cur_addr  = memory_addr;
      cur_wstrb = memory_wstrb;
      cur_instr = memory_instr;
    end
  end

  assign cur_write = (cur_wstrb != 4'b0000) && !cur_instr;
  assign cur_off   = cur_addr - BASE;
  assign cur_idx   = AW'(cur_off >> 2);

`ifdef MEMORY_RESPONDER_BOUNDS_EN
  assign cur_in_range = ({1'b0, cur_addr} >= {1'b0, BASE}) &&
                        ({1'b0, cur_addr} < ({1'b0, BASE} + 33'(DEPTH) * 33'd4));
`else
  assign cur_in_range = 1'b1;
`endif

  assign enter_resp = ((state_reg == ST_IDLE) && memory_valid && (WAIT == 0)) ||
                      ((state_reg == ST_WAIT) && (cnt_reg == 4'd0));

  // Writes commit on the edge that ends RESP, so a following read sees the new word.
  assign arr_we = (state_reg == ST_RESP) && cur_write && cur_in_range;

  always_comb begin
    resp_data = cur_write ? 32'h0 : arr_rdata;
`ifdef MEMORY_RESPONDER_BOUNDS_EN
    if (!cur_in_range) begin
      resp_data = 32'hDEAD_BEEF;
    end
`endif
  end

  memory_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wstrb (req_reg.wstrb),
    .addr  (cur_idx),
    .wdata (req_reg.wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      ready_reg <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      ready_reg <= enter_resp;
      rdata_reg <= enter_resp ? resp_data : 32'h0;
      case (state_reg)
        ST_IDLE: begin
          if (memory_valid) begin
            req_reg <= '{addr: memory_addr, wdata: memory_wdata,
                         wstrb: memory_wstrb, instr: memory_instr};
            if (WAIT > 0) begin
              state_reg <= ST_WAIT;
              cnt_reg   <= 4'(WAIT - 1);
            end else begin
              state_reg <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef MEMORY_RESPONDER_BOUNDS_EN
  logic error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_reg <= 1'b0;
    end else if (enter_resp && !cur_in_range) begin
      error_reg <= 1'b1;
    end
  end

  assign memory_error = error_reg;
`else
  assign memory_error = 1'b0;
`endif

  assign memory_ready = ready_reg;
  assign memory_rdata = rdata_reg;

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder: three instances (WAIT=1/0/5, different BASE/DEPTH) against a
// word-level reference model. Expectations follow MEMORY_RESPONDER_BOUNDS_EN when it is defined.
`timescale 1ns/1ps
module tb_memory_responder;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;
  localparam logic [31:0] BASE2 = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        valid [3];
  logic        instr [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];

  int checks = 0;
  int fails  = 0;

  memory_responder #(.BASE(BASE0), .DEPTH(1024), .WAIT(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .memory_valid(valid[0]), .memory_instr(instr[0]),
    .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
    .memory_rdata(rdata[0]), .memory_ready(ready[0]), .memory_error(err[0]));

  memory_responder #(.BASE(BASE1), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .memory_valid(valid[1]), .memory_instr(instr[1]),
    .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
    .memory_rdata(rdata[1]), .memory_ready(ready[1]), .memory_error(err[1]));

  memory_responder #(.BASE(BASE2), .DEPTH(16), .WAIT(5)) u_w5 (
    .clk(clk), .rst(rst[2]), .memory_valid(valid[2]), .memory_instr(instr[2]),
    .memory_addr(addr[2]), .memory_wdata(wdata[2]), .memory_wstrb(wstrb[2]),
    .memory_rdata(rdata[2]), .memory_ready(ready[2]), .memory_error(err[2]));

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? BASE0 : (k == 1) ? BASE1 : BASE2;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : (k == 1) ? 64 : 16;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 5;
  endfunction

  // Reference model: words keyed by instance and word index, plus a sticky error per instance.
  logic [31:0] mdl [int];
  logic        mdl_err [3];

  function automatic bit in_range(input int k, input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(base_of(k));
    return (la >= lb) && (la < lb + 4 * longint'(depth_of(k)));
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    logic [31:0] off = a - base_of(k);
    return k * 65536 + int'((off / 4) % depth_of(k));
  endfunction

  task automatic mdl_access(input int k, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic ins,
                            output logic [31:0] exp_rd, output bit known);
    int key;
    logic [31:0] word;
    exp_rd = 32'h0;
    known  = 1'b1;
`ifdef MEMORY_RESPONDER_BOUNDS_EN
    if (!in_range(k, a)) begin
      exp_rd = 32'hDEAD_BEEF;
      mdl_err[k] = 1'b1;
      return;
    end
`endif
    key = key_of(k, a);
    if (ws != 4'b0000 && !ins) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) word[b*8 +: 8] = wd[b*8 +: 8];
      end
      mdl[key] = word;
    end else if (mdl.exists(key)) begin
      exp_rd = mdl[key];
    end else begin
      known = 1'b0;
    end
  endtask

  // One handshake: lat = edges from the accept edge to the ready pulse (-1 if none in budget);
  // ready_after = memory_ready one edge after the pulse.
  task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins,
                        output logic [31:0] rd, output int lat, output logic ready_after);
    @(negedge clk);
    valid[k] = 1'b1; addr[k] = a; wdata[k] = wd; wstrb[k] = ws; instr[k] = ins;
    lat = -1;
    rd  = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (ready[k]) begin
        lat = n;
        rd  = rdata[k];
        break;
      end
    end
    valid[k] = 1'b0; wstrb[k] = 4'b0000; instr[k] = 1'b0;
    @(posedge clk); #1;
    ready_after = ready[k];
    $display("txn inst=%0d addr=%08h wdata=%08h wstrb=%b instr=%0b rdata=%08h lat=%0d err=%0b",
             k, a, wd, ws, ins, rd, lat, err[k]);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; instr[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'b0000;
      mdl_err[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready[k] !== 1'b0) begin
        fails++; $display("FAIL reset_ready inst=%0d got=%b exp=0", k, ready[k]);
      end
      checks++;
      if (rdata[k] !== 32'h0) begin
        fails++; $display("FAIL reset_rdata inst=%0d got=%08h exp=00000000", k, rdata[k]);
      end
      checks++;
      if (err[k] !== 1'b0) begin
        fails++; $display("FAIL reset_error inst=%0d got=%b exp=0", k, err[k]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, exp;
    int lat;
    logic ra;
    bit kn;
    do_req(0, 32'h10, 32'h1122_3344, 4'hF, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h10, 32'h1122_3344, 4'hF, 1'b0, exp, kn);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL write_latency got=%0d exp=1", lat); end
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL write_rdata got=%08h exp=00000000", rd); end
    checks++;
    if (ra !== 1'b0) begin fails++; $display("FAIL write_single_pulse got=%b exp=0", ra); end

    do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h10, 32'h0, 4'h0, 1'b0, exp, kn);
    checks++;
    if (rd !== 32'h1122_3344) begin fails++; $display("FAIL read_full got=%08h exp=11223344", rd); end
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL read_latency got=%0d exp=1", lat); end

    do_req(0, 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, exp, kn);
    do_req(0, 32'h13, 32'h0, 4'h0, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h13, 32'h0, 4'h0, 1'b0, exp, kn);
    checks++;
    if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL read_strobed got=%08h exp=11bb33dd", rd); end
  endtask

  task automatic test_fetch();
    logic [31:0] rd, exp;
    int lat;
    logic ra;
    bit kn;
    do_req(0, 32'h10, 32'h0, 4'hF, 1'b1, rd, lat, ra);
    mdl_access(0, 32'h10, 32'h0, 4'hF, 1'b1, exp, kn);
    checks++;
    if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL fetch_rdata got=%08h exp=11bb33dd", rd); end
    do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h10, 32'h0, 4'h0, 1'b0, exp, kn);
    checks++;
    if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL fetch_no_write got=%08h exp=11bb33dd", rd); end
  endtask

  task automatic test_bounds();
    logic [31:0] rd, exp;
    int lat;
    logic ra;
    bit kn;
    do_req(0, 32'h0, 32'h5A5A_0001, 4'hF, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h0, 32'h5A5A_0001, 4'hF, 1'b0, exp, kn);
    do_req(0, 32'h1000, 32'h0, 4'h0, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h1000, 32'h0, 4'h0, 1'b0, exp, kn);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL bounds_latency got=%0d exp=1", lat); end
`ifdef MEMORY_RESPONDER_BOUNDS_EN
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bounds_rdata got=%08h exp=deadbeef", rd); end
    checks++;
    if (err[0] !== 1'b1) begin fails++; $display("FAIL bounds_error_set got=%b exp=1", err[0]); end
    do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
    mdl_access(0, 32'h10, 32'h0, 4'h0, 1'b0, exp, kn);
    checks++;
    if (err[0] !== 1'b1) begin fails++; $display("FAIL bounds_error_sticky got=%b exp=1", err[0]); end
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    mdl_err[0] = 1'b0;
    #1;
    checks++;
    if (err[0] !== 1'b0) begin fails++; $display("FAIL bounds_error_cleared got=%b exp=0", err[0]); end
`else
    checks++;
    if (rd !== 32'h5A5A_0001) begin fails++; $display("FAIL wrap_rdata got=%08h exp=5a5a0001", rd); end
    checks++;
    if (err[0] !== 1'b0) begin fails++; $display("FAIL wrap_error got=%b exp=0", err[0]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    logic [31:0] vals [3];
    int lat, pulses;
    logic ra, exp_ready;
    bit kn;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      do_req(1, BASE1 + 32'(4 * i), vals[i], 4'hF, 1'b0, rd, lat, ra);
      mdl_access(1, BASE1 + 32'(4 * i), vals[i], 4'hF, 1'b0, exp, kn);
    end
    pulses = 0;
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = BASE1; wstrb[1] = 4'h0; instr[1] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      exp_ready = ((n % 2) == 0) && (n < 6);
      checks++;
      if (ready[1] !== exp_ready) begin
        fails++; $display("FAIL b2b_ready edge=%0d got=%b exp=%b", n, ready[1], exp_ready);
      end
      if (ready[1] === 1'b1) begin
        if (pulses < 3) begin
          checks++;
          if (rdata[1] !== vals[pulses]) begin
            fails++; $display("FAIL b2b_rdata pulse=%0d got=%08h exp=%08h", pulses, rdata[1], vals[pulses]);
          end
        end
        pulses++;
        if (pulses >= 3) valid[1] = 1'b0;
        else addr[1] = BASE1 + 32'(4 * pulses);
      end else begin
        checks++;
        if (rdata[1] !== 32'h0) begin
          fails++; $display("FAIL b2b_rdata_idle edge=%0d got=%08h exp=00000000", n, rdata[1]);
        end
      end
    end
    valid[1] = 1'b0;
    checks++;
    if (pulses !== 3) begin fails++; $display("FAIL b2b_pulse_count got=%0d exp=3", pulses); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, exp, old_val, a;
    int lat, seen;
    logic ra;
    bit kn;
    a = BASE2 + 32'h20;
    old_val = $urandom;
    do_req(2, a, old_val, 4'hF, 1'b0, rd, lat, ra);
    mdl_access(2, a, old_val, 4'hF, 1'b0, exp, kn);
    seen = 0;
    @(negedge clk);
    valid[2] = 1'b1; addr[2] = a; wdata[2] = ~old_val; wstrb[2] = 4'hF; instr[2] = 1'b0;
    @(posedge clk); #1;
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    if (ready[2]) seen++;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready[2]) seen++;
    end
    // Reset two cycles into the wait; a read is already pending when it releases.
    rst[2] = 1'b1;
    valid[2] = 1'b1; addr[2] = a; wstrb[2] = 4'h0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready[2]) seen++;
    end
    @(negedge clk);
    rst[2] = 1'b0;
    mdl_err[2] = 1'b0;
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
    lat = -1;
    rd = 32'h0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ready[2]) begin lat = n; rd = rdata[2]; break; end
    end
    valid[2] = 1'b0;
    @(posedge clk); #1;
    $display("txn inst=2 addr=%08h (held through reset) rdata=%08h lat=%0d", a, rd, lat);
    checks++;
    if (lat !== 5) begin fails++; $display("FAIL abort_accept_latency got=%0d exp=5", lat); end
    checks++;
    if (rd !== old_val) begin fails++; $display("FAIL abort_old_value got=%08h exp=%08h", rd, old_val); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, a, wd;
    logic [3:0] ws;
    logic ins, ra;
    int lat, k, w, kind;
    bit kn;
    for (int kk = 0; kk < 3; kk++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        do_req(kk, base_of(kk) + 32'(4 * i), wd, 4'hF, 1'b0, rd, lat, ra);
        mdl_access(kk, base_of(kk) + 32'(4 * i), wd, 4'hF, 1'b0, exp, kn);
      end
    end
    for (int i = 0; i < 45; i++) begin
      k    = int'($urandom_range(0, 2));
      w    = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 7));
      case (kind)
        0:       a = base_of(k) - 32'(4 * (depth_of(k) - w));
        1:       a = base_of(k) + 32'(4 * depth_of(k)) + 32'(4 * w);
        default: a = base_of(k) + 32'(4 * w) + 32'($urandom_range(0, 3));
      endcase
      wd  = $urandom;
      ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ins = ($urandom_range(0, 4) == 0);
      do_req(k, a, wd, ws, ins, rd, lat, ra);
      mdl_access(k, a, wd, ws, ins, exp, kn);
      checks++;
      if (lat !== wait_of(k)) begin
        fails++; $display("FAIL rand_latency op=%0d inst=%0d got=%0d exp=%0d", i, k, lat, wait_of(k));
      end
      if (kn) begin
        checks++;
        if (rd !== exp) begin
          fails++; $display("FAIL rand_rdata op=%0d inst=%0d addr=%08h got=%08h exp=%08h", i, k, a, rd, exp);
        end
      end
      checks++;
      if (err[k] !== mdl_err[k]) begin
        fails++; $display("FAIL rand_error op=%0d inst=%0d got=%b exp=%b", i, k, err[k], mdl_err[k]);
      end
      checks++;
      if (ra !== 1'b0) begin
        fails++; $display("FAIL rand_single_pulse op=%0d inst=%0d got=%b exp=0", i, k, ra);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fetch();
    test_bounds();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h0000_0000, meaning the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words, a power of two from 16 to 65536.
REQ-003 The block SHALL have parameter WAIT, default 1, meaning the wait cycles inserted before each response, from 0 to 15.
REQ-004 The block SHALL have port clk, input, width 1: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, which is synchronous and active-high.
REQ-006 The block SHALL have port memory_valid, input, width 1: the initiator's request, held high until memory_ready is seen.
REQ-007 The block SHALL have port memory_instr, input, width 1: marks the request as an instruction fetch.
REQ-008 The block SHALL have port memory_addr, input, width 32: the byte address.
REQ-009 The block SHALL have port memory_wdata, input, width 32: the write data.
REQ-010 The block SHALL have port memory_wstrb, input, width 4: per-byte write enables, where 4'b0000 means a read.
REQ-011 The block SHALL have port memory_rdata, output, width 32: the read data, valid only while memory_ready is 1.
REQ-012 The block SHALL have port memory_ready, output, width 1: a one-cycle response pulse.
REQ-013 The block SHALL have port memory_error, output, width 1: a sticky flag for out-of-range accesses.

Function
REQ-014 The state machine SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE with memory_valid=1, the block SHALL latch addr, wdata, wstrb and instr, and move to WAIT if WAIT>0, else to RESP.
REQ-016 Input changes after acceptance SHALL be ignored until the block returns to IDLE.
REQ-017 WAIT SHALL load a 4-bit counter with WAIT-1, decrement it each cycle, and move to RESP after the cycle in which the counter reads 0.
REQ-018 In RESP, memory_ready SHALL be 1 for exactly one cycle, and the next state SHALL unconditionally be IDLE.
REQ-019 A request accepted on edge T SHALL see memory_ready high in cycle T+1+WAIT.
REQ-020 memory_valid seen during WAIT or RESP SHALL NOT start a new request; the earliest next acceptance SHALL be the cycle after RESP, so the peak rate is 1 request per WAIT+2 cycles.
REQ-021 The word index SHALL be (addr-BASE)[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-022 A write (wstrb!=0 and instr=0) SHALL update only the strobed byte lanes, committed on the edge ending RESP.
REQ-023 In a write's RESP cycle, memory_rdata SHALL be 0.
REQ-024 A read SHALL return the full word, with memory_rdata driven only during RESP and 0 otherwise.
REQ-025 For instr=1 with wstrb!=0, the block SHALL perform a read and SHALL NOT write.
REQ-026 A read to a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-027 When rst=1 at an edge, the block SHALL set state to IDLE, the counter to 0, memory_ready to 0, memory_rdata to 0 and memory_error to 0.
REQ-028 When rst=1 at an edge, the block SHALL abandon any in-flight request without a write or a response.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 A request held on memory_valid while rst deasserts SHALL be accepted on the first edge with rst=0.

Configuration
REQ-031 With macro MEMORY_RESPONDER_BOUNDS_EN defined, an access with addr<BASE or addr>=BASE+4*DEPTH SHALL still respond with normal timing.
REQ-032 With MEMORY_RESPONDER_BOUNDS_EN defined, such an access SHALL perform no write, SHALL return 32'hDEAD_BEEF, and SHALL set memory_error until reset.
REQ-033 Without MEMORY_RESPONDER_BOUNDS_EN, addresses SHALL wrap modulo DEPTH words, and memory_error SHALL be tied to 0.

Structure
REQ-034 The package configure SHALL hold the defaults mem_base, mem_depth and mem_wait.
REQ-035 The package wires SHALL hold the state enum and the latched-request struct (addr, wdata, wstrb, instr).
REQ-036 The block SHALL contain one sub-module, memory_array: a DEPTH x 32 array with a byte-write port and a combinational read.
REQ-037 The FSM, counter and bounds check SHALL live in memory_responder.

Verification
REQ-038 Reset, then with WAIT=1 write 0x0000_0010 with wdata 0x1122_3344 and wstrb 4'hF -> ready in T+2 with rdata 0; a following read of 0x10 returns 0x1122_3344.
REQ-039 Write 0x10 with wdata 0xAABB_CCDD and wstrb 4'b0101, then read 0x10 -> 0x11BB_33DD.
REQ-040 With WAIT=0, hold memory_valid across 3 reads -> ready every 2nd cycle, exactly 3 pulses, none during the held RESP cycle.
REQ-041 Fetch with memory_instr=1, wstrb=4'hF and wdata 0 at 0x10, then read 0x10 -> 0x11BB_33DD, unchanged.
REQ-042 With BOUNDS_EN, read 0x0000_1000 (DEPTH=1024) -> rdata 0xDEAD_BEEF, memory_error=1 until rst; without the macro, the same read returns word 0.
REQ-043 With WAIT=5, assert rst 2 cycles after accepting a write to 0x20 -> no ready pulse, and a later read of 0x20 returns the old value.
